// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
   localparam int XLEN_DEFAULT = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [31:0]             inst;
      logic [XLEN_DEFAULT-1:0] advance_pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch-unit bus: instruction-memory port, redirect request, decode handshake.
interface fetch_if #(
   parameter int XLEN = fetch_pkg::XLEN_DEFAULT
);
   logic [XLEN-1:0] imem_addr_o;
   logic [31:0]     imem_data_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [XLEN-1:0] out_pc_o;
   logic [31:0]     out_inst_o;
   logic [XLEN-1:0] out_advance_pc_o;

   modport master (
      output imem_addr_o,
      input  imem_data_i,
      input  redirect_i,
      input  redirect_pc_i,
      output out_valid_o,
      input  out_ready_i,
      output out_pc_o,
      output out_inst_o,
      output out_advance_pc_o
   );

   modport slave (
      input  imem_addr_o,
      output imem_data_i,
      output redirect_i,
      output redirect_pc_i,
      input  out_valid_o,
      output out_ready_i,
      input  out_pc_o,
      input  out_inst_o,
      input  out_advance_pc_o
   );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry queue of fetch entries with push, pop and a flush that wins over both.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   output fetch_entry_t             head_entry,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   fetch_entry_t  mem [DEPTH];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: count alone decides which slots are live.
   always_ff @(posedge clk_i) begin
      if (push && !flush) mem[tail] <= push_entry;
   end

   assign head_entry = mem[head];
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, fetch queue and decode handshake.
// Optional FETCH_BYPASS_EN presents the imem word directly when the queue is empty.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   fetch_if.master                bus,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   if (XLEN != XLEN_DEFAULT) begin : g_xlen_check
      $error("fetch_unit: XLEN must match fetch_pkg::XLEN_DEFAULT");
   end

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   fetch_entry_t    cur_entry;
   fetch_entry_t    head_entry;
   logic            queue_valid;
   logic            bypass;
   logic            pop_req;
   logic            fetch;
   logic            fifo_push;
   logic            fifo_pop;
   logic            unused_redirect_bits;

   assign unused_redirect_bits = ^bus.redirect_pc_i[1:0];

   assign pc_next   = pc + XLEN'(4);
   assign cur_entry = '{pc: pc, inst: bus.imem_data_i, advance_pc: pc_next};

   assign queue_valid = (count_o != '0);

`ifdef FETCH_BYPASS_EN
   assign bypass = !queue_valid && start_i && !bus.redirect_i;
`else
   assign bypass = 1'b0;
`endif

   // A redirect cancels the pop even when decode is ready.
   assign pop_req   = bus.out_valid_o && bus.out_ready_i && !bus.redirect_i;
   assign fetch     = start_i && !bus.redirect_i && ((count_o != FULL_CNT) || pop_req);
   assign fifo_pop  = pop_req && queue_valid;
   assign fifo_push = fetch && !(bypass && bus.out_ready_i);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc <= RESET_PC;
      end else if (bus.redirect_i) begin
         pc <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
      end else if (fetch) begin
         pc <= pc_next;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush      (bus.redirect_i),
      .push       (fifo_push),
      .push_entry (cur_entry),
      .pop        (fifo_pop),
      .head_entry (head_entry),
      .count      (count_o)
   );

   assign bus.imem_addr_o = pc;

`ifdef FETCH_BYPASS_EN
   always_comb begin
      bus.out_valid_o      = queue_valid || bypass;
      bus.out_pc_o         = head_entry.pc;
      bus.out_inst_o       = NOP;
      bus.out_advance_pc_o = head_entry.advance_pc;
      if (queue_valid) begin
         bus.out_inst_o = head_entry.inst;
      end else if (bypass) begin
         bus.out_pc_o         = cur_entry.pc;
         bus.out_inst_o       = cur_entry.inst;
         bus.out_advance_pc_o = cur_entry.advance_pc;
      end
   end
`else
   assign bus.out_valid_o      = queue_valid || bypass;
   assign bus.out_pc_o         = head_entry.pc;
   assign bus.out_inst_o       = queue_valid ? head_entry.inst : NOP;
   assign bus.out_advance_pc_o = head_entry.advance_pc;
`endif
endmodule
